dma_fifo_ctrl: RTL and testbench
================================

Name: dma_fifo_ctrl

Overview:
- Longword FIFO with pointer and flag logic, between the CPU-side DMA state machine and the SCSI-side byte state machine.
- Consumes the strobes INCFIFO, DECFIFO, INCNI, INCNO and INCBO.
- Produces FIFOEMPTY, FIFOFULL, BOEQ0 and BOEQ3, which the CPU-side state machine samples.
- Holds DEPTH x 32-bit entries. Entries are written as longwords or words from the CPU side, or as single bytes from the SCSI side.

Parameters:
- DEPTH, 8, number of longword entries; must be a power of two, 2 to 16.
- DATA_W, 32, entry width in bits; fixed at 32 (four byte lanes).

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- aRESET_  in  1  asynchronous active-low reset.
- FIFO_CLR  in  1  synchronous clear of all pointers and counters (register write / flush abort).
- INCFIFO  in  1  word count +1 (an entry was completed).
- DECFIFO  in  1  word count -1 (an entry was consumed).
- INCNI  in  1  advance write (next-in) pointer.
- INCNO  in  1  advance read (next-out) pointer.
- INCBO  in  1  advance byte offset counter (SCSI side).
- WR_BE  in  4  byte-lane write enables for entry[WPTR]; bit3 = D[31:24].
- WR_DATA  in  32  write data.
- BYTE_WR  in  1  SCSI byte write: lane = BO, data taken from WR_DATA[7:0]; WR_BE ignored.
- RD_DATA  out  32  entry[RPTR], combinational from registered storage and pointer.
- RD_BYTE  out  8  lane BO of entry[RPTR].
- FIFOEMPTY  out  1  word count == 0.
- FIFOFULL  out  1  word count == DEPTH.
- BOEQ0  out  1  BO == 0.
- BOEQ3  out  1  BO == 3.
- BO  out  2  byte offset counter.

Behaviour:
- Reset state (async assert, release synchronous to CLK): WPTR=0, RPTR=0, COUNT=0, BO=0, FIFOEMPTY=1, FIFOFULL=0, BOEQ0=1, BOEQ3=0. Storage contents are not reset.
- FIFO_CLR has the same effect as reset, one cycle later, and takes priority over every strobe in the same cycle.
- WPTR and RPTR are log2(DEPTH) bits wide and wrap modulo DEPTH.
- COUNT is log2(DEPTH)+1 bits wide.
- Flags are decoded from registered COUNT and BO, so they reflect a strobe on the cycle after it. There is no combinational path from strobes to flags.
- INCFIFO and DECFIFO in the same cycle: COUNT is unchanged.
- INCFIFO alone while FIFOFULL: COUNT is held (saturates).
- DECFIFO alone while FIFOEMPTY: COUNT is held at 0.
- INCNI and INCNO are independent of COUNT. They always advance, and both may advance in the same cycle. Keeping them consistent with COUNT is the state machines' job.
- BO wraps 3 -> 0 on INCBO. INCBO must not be blocked by flag state.
- Storage write:
  - On CLK, each lane with WR_BE[i]=1 is written into entry[WPTR].
  - A write and INCNI in the same cycle use the pre-increment WPTR.
  - BYTE_WR writes lane BO using the pre-increment BO when INCBO coincides.
  - Lane mapping is big-endian: BO=0 -> [31:24], BO=3 -> [7:0].
- Read: RD_DATA/RD_BYTE follow RPTR/BO with no added latency. A write to the entry being read is visible the following cycle (no bypass).

Optional Feature:
- Macro: DMA_FIFO_ERR_EN.
- When defined, adds outputs FIFO_OVF and FIFO_UDF:
  - FIFO_OVF is set by INCFIFO without DECFIFO while FIFOFULL.
  - FIFO_UDF is set by DECFIFO without INCFIFO while FIFOEMPTY.
  - Both are sticky until reset or FIFO_CLR; both reset to 0.
- When not defined, neither port exists and saturation is silent.

Decomposition:
- Package dma_fifo_pkg holds:
  - DEPTH default.
  - PTR_W = $clog2(DEPTH) and CNT_W = PTR_W+1.
  - Lane index function lane_of(bo) = 3 - bo.
- One sub-module, dma_fifo_ram: DEPTH x 4 byte-lane register array with per-lane write enables and asynchronous read port. Pointers, counters and flags stay in dma_fifo_ctrl.

Test Plan:
- Reset: hold aRESET_=0 mid-traffic -> FIFOEMPTY=1, FIFOFULL=0, BO=0, BOEQ0=1 immediately. After release, the first INCFIFO gives COUNT=1 and FIFOEMPTY=0 one cycle later.
- Fill/drain: 8x(WR_BE=4'hF, WR_DATA=32'h1000_0000+i, INCNI, INCFIFO) -> FIFOFULL=1 after the 8th. Then 8x(INCNO, DECFIFO) -> RD_DATA sequence 0x1000_0000..0x1000_0007, FIFOEMPTY=1, WPTR=RPTR=0 (wrap).
- Byte assembly: BYTE_WR with 0xDE,0xAD,0xBE,0xEF and INCBO each cycle -> entry[0]=0xDEADBEEF. BOEQ3=1 after the 3rd INCBO; BOEQ0=1 after the 4th.
- Simultaneous: COUNT=4, INCFIFO+DECFIFO together for 3 cycles -> COUNT stays 4, flags unchanged. FIFO_CLR together with INCFIFO -> COUNT=0.
- Saturation: FIFOFULL with INCFIFO -> COUNT stays 8. FIFOEMPTY with DECFIFO -> COUNT stays 0. With DMA_FIFO_ERR_EN, FIFO_OVF/FIFO_UDF go to 1 and hold until FIFO_CLR.
- Word write: WR_BE=4'b0011, WR_DATA=0x1234_5678 over entry 0xFFFF_FFFF -> RD_DATA=0xFFFF_5678 the next cycle.

Source files
------------

// File: rtl/dma_fifo_pkg.sv
// Shared constants and helpers for the DMA longword FIFO (dma_fifo_ctrl, dma_fifo_ram).
package dma_fifo_pkg;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DATA_W        = 32;
  localparam int LANES         = 4;
  localparam int PTR_W         = $clog2(DEFAULT_DEPTH);
  localparam int CNT_W         = PTR_W + 1;

  // Big-endian lane select: byte offset 0 is D[31:24], which is lane 3.
  function automatic logic [1:0] lane_of(input logic [1:0] bo);
    return 2'd3 - bo;
  endfunction
endpackage

// File: rtl/dma_fifo_ram.sv
// DEPTH x 4 byte-lane register array, per-lane write enables, asynchronous read.
module dma_fifo_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic [AW-1:0]                     waddr,
  input  logic [dma_fifo_pkg::LANES-1:0]    be,
  input  logic [dma_fifo_pkg::DATA_W-1:0]   wdata,
  input  logic [AW-1:0]                     raddr,
  output logic [dma_fifo_pkg::DATA_W-1:0]   rdata
);
  import dma_fifo_pkg::*;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/dma_fifo_ctrl.sv
// DMA longword FIFO: pointers, word count, byte offset and status flags around dma_fifo_ram.
// Optional macro DMA_FIFO_ERR_EN adds sticky FIFO_OVF / FIFO_UDF outputs.
module dma_fifo_ctrl #(
  parameter int DEPTH  = dma_fifo_pkg::DEFAULT_DEPTH,
  parameter int DATA_W = dma_fifo_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              aRESET_,
  input  logic              FIFO_CLR,
  input  logic              INCFIFO,
  input  logic              DECFIFO,
  input  logic              INCNI,
  input  logic              INCNO,
  input  logic              INCBO,
  input  logic [3:0]        WR_BE,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              BYTE_WR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic [7:0]        RD_BYTE,
  output logic              FIFOEMPTY,
  output logic              FIFOFULL,
  output logic              BOEQ0,
  output logic              BOEQ3,
`ifdef DMA_FIFO_ERR_EN
  output logic              FIFO_OVF,
  output logic              FIFO_UDF,
`endif
  output logic [1:0]        BO
);
  import dma_fifo_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nxt;
  logic [1:0]    bo_q;
  logic          empty, full;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wd;

  // Flags decode registered state only, so a strobe shows up one cycle later.
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign FIFOEMPTY = empty;
  assign FIFOFULL  = full;
  assign BO        = bo_q;
  assign BOEQ0     = (bo_q == 2'd0);
  assign BOEQ3     = (bo_q == 2'd3);

  always_comb begin
    count_nxt = count;
    if (INCFIFO && !DECFIFO && !full)       count_nxt = count + 1'b1;
    else if (DECFIFO && !INCFIFO && !empty) count_nxt = count - 1'b1;
  end

  always_ff @(posedge CLK or negedge aRESET_) begin
    if (!aRESET_) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      bo_q  <= '0;
    end else if (FIFO_CLR) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      bo_q  <= '0;
    end else begin
      if (INCNI) wptr <= wptr + 1'b1;
      if (INCNO) rptr <= rptr + 1'b1;
      if (INCBO) bo_q <= bo_q + 2'd1;
      count <= count_nxt;
    end
  end

`ifdef DMA_FIFO_ERR_EN
  always_ff @(posedge CLK or negedge aRESET_) begin
    if (!aRESET_) begin
      FIFO_OVF <= 1'b0;
      FIFO_UDF <= 1'b0;
    end else if (FIFO_CLR) begin
      FIFO_OVF <= 1'b0;
      FIFO_UDF <= 1'b0;
    end else begin
      if (INCFIFO && !DECFIFO && full)  FIFO_OVF <= 1'b1;
      if (DECFIFO && !INCFIFO && empty) FIFO_UDF <= 1'b1;
    end
  end
`endif

  // SCSI byte writes replicate the byte and enable only the lane at BO.
  always_comb begin
    ram_be = WR_BE;
    ram_wd = WR_DATA;
    if (BYTE_WR) begin
      ram_be = 4'b0001 << lane_of(bo_q);
      ram_wd = {4{WR_DATA[7:0]}};
    end
  end

  dma_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (CLK),
    .waddr (wptr),
    .be    (ram_be),
    .wdata (ram_wd),
    .raddr (rptr),
    .rdata (RD_DATA)
  );

  assign RD_BYTE = RD_DATA[{lane_of(bo_q), 3'b000} +: 8];
endmodule

// File: tb/tb_dma_fifo_ctrl.sv
// Directed table-driven bench for dma_fifo_ctrl plus hand sequences for reset, bypass and error flags.
module tb_dma_fifo_ctrl;
  localparam logic [6:0] S_CLR = 7'b1000000;
  localparam logic [6:0] S_INC = 7'b0100000;
  localparam logic [6:0] S_DEC = 7'b0010000;
  localparam logic [6:0] S_NI  = 7'b0001000;
  localparam logic [6:0] S_NO  = 7'b0000100;
  localparam logic [6:0] S_BI  = 7'b0000010;
  localparam logic [6:0] S_BW  = 7'b0000001;

  typedef struct {
    string       name;
    logic [6:0]  strb;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        e_empty;
    logic        e_full;
    logic [1:0]  e_bo;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  logic        CLK = 1'b0;
  logic        aRESET_;
  logic        FIFO_CLR, INCFIFO, DECFIFO, INCNI, INCNO, INCBO, BYTE_WR;
  logic [3:0]  WR_BE;
  logic [31:0] WR_DATA;
  logic [31:0] RD_DATA;
  logic [7:0]  RD_BYTE;
  logic        FIFOEMPTY, FIFOFULL, BOEQ0, BOEQ3;
  logic [1:0]  BO;
`ifdef DMA_FIFO_ERR_EN
  logic        FIFO_OVF, FIFO_UDF;
`endif

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[$];

  dma_fifo_ctrl dut (
    .CLK(CLK), .aRESET_(aRESET_), .FIFO_CLR(FIFO_CLR),
    .INCFIFO(INCFIFO), .DECFIFO(DECFIFO), .INCNI(INCNI), .INCNO(INCNO), .INCBO(INCBO),
    .WR_BE(WR_BE), .WR_DATA(WR_DATA), .BYTE_WR(BYTE_WR),
    .RD_DATA(RD_DATA), .RD_BYTE(RD_BYTE), .FIFOEMPTY(FIFOEMPTY), .FIFOFULL(FIFOFULL),
    .BOEQ0(BOEQ0), .BOEQ3(BOEQ3),
`ifdef DMA_FIFO_ERR_EN
    .FIFO_OVF(FIFO_OVF), .FIFO_UDF(FIFO_UDF),
`endif
    .BO(BO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] be, input logic [31:0] wd);
    FIFO_CLR = s[6]; INCFIFO = s[5]; DECFIFO = s[4]; INCNI = s[3];
    INCNO = s[2]; INCBO = s[1]; BYTE_WR = s[0]; WR_BE = be; WR_DATA = wd;
  endtask

  task automatic idle();
    drive(7'b0, 4'b0, 32'h0);
  endtask

  task automatic check_flags(input string nm, input logic e_empty, input logic e_full, input logic [1:0] e_bo);
    check({nm, ".empty"}, 32'(FIFOEMPTY), 32'(e_empty));
    check({nm, ".full"},  32'(FIFOFULL),  32'(e_full));
    check({nm, ".bo"},    32'(BO),        32'(e_bo));
    check({nm, ".boeq0"}, 32'(BOEQ0),     32'(e_bo == 2'd0));
    check({nm, ".boeq3"}, 32'(BOEQ3),     32'(e_bo == 2'd3));
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] rd, input logic [1:0] bo);
    logic [31:0] sh;
    sh = rd >> (8 * (3 - int'(bo)));
    return sh[7:0];
  endfunction

  function automatic void add(input string nm, input logic [6:0] s, input logic [3:0] be,
                              input logic [31:0] wd, input logic e_empty, input logic e_full,
                              input logic [1:0] e_bo, input logic chk, input logic [31:0] e_rd);
    vec_t v;
    v.name = nm; v.strb = s; v.be = be; v.wd = wd;
    v.e_empty = e_empty; v.e_full = e_full; v.e_bo = e_bo; v.chk_rd = chk; v.e_rd = e_rd;
    vecs.push_back(v);
  endfunction

  initial begin
    // Fill 8 entries, then drain them; both pointers wrap back to 0.
    for (int i = 0; i < 8; i++)
      add($sformatf("fill%0d", i), S_INC | S_NI, 4'hF, 32'h1000_0000 + i, 1'b0, i == 7, 2'd0, 1'b1, 32'h1000_0000);
    for (int j = 0; j < 8; j++)
      add($sformatf("drain%0d", j), S_DEC | S_NO, 4'h0, 32'h0, j == 7, 1'b0, 2'd0, 1'b1, 32'h1000_0000 + ((j + 1) % 8));
    // Byte assembly into entry 0 from the SCSI side.
    add("byte0", S_BW | S_BI, 4'h0, 32'h0000_00DE, 1'b1, 1'b0, 2'd1, 1'b1, 32'hDE00_0000);
    add("byte1", S_BW | S_BI, 4'hF, 32'hFFFF_FFAD, 1'b1, 1'b0, 2'd2, 1'b1, 32'hDEAD_0000);
    add("byte2", S_BW | S_BI, 4'h0, 32'h0000_00BE, 1'b1, 1'b0, 2'd3, 1'b1, 32'hDEAD_BE00);
    add("byte3", S_BW | S_BI, 4'h0, 32'h0000_00EF, 1'b1, 1'b0, 2'd0, 1'b1, 32'hDEAD_BEEF);
    // Partial-lane word write.
    add("word_ff", 7'b0, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'd0, 1'b1, 32'hFFFF_FFFF);
    add("word_lo", 7'b0, 4'b0011, 32'h1234_5678, 1'b1, 1'b0, 2'd0, 1'b1, 32'hFFFF_5678);
    // COUNT=4, then simultaneous inc/dec must leave it at 4.
    for (int i = 0; i < 4; i++) add($sformatf("cnt4_%0d", i), S_INC, 4'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 32'hFFFF_5678);
    for (int i = 0; i < 3; i++) add($sformatf("incdec%0d", i), S_INC | S_DEC, 4'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) add($sformatf("dec4_%0d", i), S_DEC, 4'h0, 32'h0, i == 3, 1'b0, 2'd0, 1'b0, 32'h0);
    add("incdec_empty", S_INC | S_DEC, 4'h0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0);
    // FIFO_CLR beats every strobe in the same cycle.
    add("pre_clr", S_INC | S_BI, 4'h0, 32'h0, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0);
    add("clr", S_CLR | S_INC | S_BI | S_NI | S_NO, 4'h0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 32'hFFFF_5678);
    // Saturation at both ends.
    for (int i = 0; i < 8; i++) add($sformatf("sat_fill%0d", i), S_INC, 4'h0, 32'h0, 1'b0, i == 7, 2'd0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) add($sformatf("sat_over%0d", i), S_INC, 4'h0, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) add($sformatf("sat_drain%0d", i), S_DEC, 4'h0, 32'h0, i == 7, 1'b0, 2'd0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) add($sformatf("sat_under%0d", i), S_DEC, 4'h0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0);
    add("after_under_inc", S_INC, 4'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
    add("after_under_dec", S_DEC, 4'h0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0);

    // Reset state straight out of power-up.
    aRESET_ = 1'b0;
    idle();
    repeat (3) @(posedge CLK);
    #1 check_flags("reset", 1'b1, 1'b0, 2'd0);
    @(negedge CLK) aRESET_ = 1'b1;

    foreach (vecs[k]) begin
      @(negedge CLK);
      drive(vecs[k].strb, vecs[k].be, vecs[k].wd);
      @(posedge CLK);
      #1;
      check_flags(vecs[k].name, vecs[k].e_empty, vecs[k].e_full, vecs[k].e_bo);
      if (vecs[k].chk_rd) begin
        check({vecs[k].name, ".rd_data"}, RD_DATA, vecs[k].e_rd);
        check({vecs[k].name, ".rd_byte"}, 32'(RD_BYTE), 32'(exp_byte(vecs[k].e_rd, vecs[k].e_bo)));
      end
    end

    // No write bypass: new data to entry[RPTR] appears only after the edge.
    @(negedge CLK);
    drive(7'b0, 4'hF, 32'hA5A5_A5A5);
    #1 check("nobypass.before", RD_DATA, 32'hFFFF_5678);
    @(posedge CLK);
    #1 check("nobypass.after", RD_DATA, 32'hA5A5_A5A5);

    // Asynchronous reset in the middle of traffic.
    @(negedge CLK);
    drive(S_INC | S_BI, 4'h0, 32'h0);
    repeat (2) @(posedge CLK);
    #1 check_flags("pre_areset", 1'b0, 1'b0, 2'd2);
    @(negedge CLK);
    #2 aRESET_ = 1'b0;
    #1 check_flags("areset_async", 1'b1, 1'b0, 2'd0);
    @(negedge CLK);
    idle();
    aRESET_ = 1'b1;
    @(posedge CLK);
    #1 check_flags("post_release", 1'b1, 1'b0, 2'd0);
    @(negedge CLK);
    drive(S_INC, 4'h0, 32'h0);
    @(posedge CLK);
    #1 check_flags("first_inc", 1'b0, 1'b0, 2'd0);

`ifdef DMA_FIFO_ERR_EN
    @(negedge CLK);
    drive(S_CLR, 4'h0, 32'h0);
    @(posedge CLK);
    #1 check("err.clr_udf", 32'(FIFO_UDF), 32'd0);
    @(negedge CLK);
    drive(S_DEC, 4'h0, 32'h0);
    @(posedge CLK);
    #1 check("err.udf_set", 32'(FIFO_UDF), 32'd1);
    @(negedge CLK);
    drive(S_INC, 4'h0, 32'h0);
    repeat (8) @(posedge CLK);
    #1 check("err.udf_hold", 32'(FIFO_UDF), 32'd1);
    check("err.ovf_not_yet", 32'(FIFO_OVF), 32'd0);
    @(posedge CLK);
    #1 check("err.ovf_set", 32'(FIFO_OVF), 32'd1);
    @(negedge CLK);
    idle();
    @(posedge CLK);
    #1 check("err.ovf_hold", 32'(FIFO_OVF), 32'd1);
    @(negedge CLK);
    drive(S_CLR, 4'h0, 32'h0);
    @(posedge CLK);
    #1 check("err.ovf_clr", 32'(FIFO_OVF), 32'd0);
    check("err.udf_clr", 32'(FIFO_UDF), 32'd0);
`endif

    @(negedge CLK);
    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
